// File: rtl/fma_layer_seq_if.sv
// rtl/fma_layer_seq_if.sv - job, beat, FMA and result signal bundle for fma_layer_seq
interface fma_layer_seq_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int OUTPUT_WIDTH = 16,
    parameter int MAX_LEN      = 256
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int SW = $clog2(OUTPUT_WIDTH);

    // job request
    logic                                 start;
    logic [LW-1:0]                        len;
    logic [SW-1:0]                        shift;
    logic                                 relu_en;
    logic [VECTOR_WIDTH*OUTPUT_WIDTH-1:0] bias;
    logic                                 busy;

    // input beats
    logic                                 in_valid;
    logic                                 in_ready;
    logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   in_val;
    logic [VECTOR_WIDTH*WEIGHT_WIDTH-1:0] in_weight;

    // FMA lane group
    logic                                 fma_mode;
    logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   fma_val;
    logic [VECTOR_WIDTH*WEIGHT_WIDTH-1:0] fma_weight;
    logic [VECTOR_WIDTH*OUTPUT_WIDTH-1:0] fma_bias;
    logic [VECTOR_WIDTH*OUTPUT_WIDTH-1:0] fma_sum;

    // result
    logic                                 out_valid;
    logic                                 out_ready;
    logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   out_data;

    // sequencer side
    modport master (
        input  start, len, shift, relu_en, bias,
        input  in_valid, in_val, in_weight,
        input  fma_sum, out_ready,
        output busy, in_ready,
        output fma_mode, fma_val, fma_weight, fma_bias,
        output out_valid, out_data
    );

    // environment side (job source, beat source, FMA, result sink)
    modport slave (
        output start, len, shift, relu_en, bias,
        output in_valid, in_val, in_weight,
        output fma_sum, out_ready,
        input  busy, in_ready,
        input  fma_mode, fma_val, fma_weight, fma_bias,
        input  out_valid, out_data
    );
endinterface

// File: rtl/fma_layer_seq.sv
// rtl/fma_layer_seq.sv - FMA job sequencer with drain, requant, ReLU and saturation
module fma_layer_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int OUTPUT_WIDTH = 16,
    parameter int MAX_LEN      = 256
) (
    input  logic           clk,
    input  logic           rstn,
    fma_layer_seq_if.master bus
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int SW = $clog2(OUTPUT_WIDTH);

    localparam logic signed [OUTPUT_WIDTH-1:0] SAT_MAX = OUTPUT_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [OUTPUT_WIDTH-1:0] SAT_MIN = OUTPUT_WIDTH'(-(2 ** (DATA_WIDTH - 1)));

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BIAS  = 3'd1,
        S_ACC   = 3'd2,
        S_DRAIN = 3'd3,
        S_WB    = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t                                r_state;
    state_t                                w_next;
    logic [LW-1:0]                         r_len;
    logic [SW-1:0]                         r_shift;
    logic                                  r_relu;
    logic [VECTOR_WIDTH*OUTPUT_WIDTH-1:0]  r_bias;
    logic [LW-1:0]                         r_cnt;
    logic                                  r_run;
    logic [VECTOR_WIDTH*DATA_WIDTH-1:0]    r_out_data;

    logic                                  w_accept;
    logic [LW-1:0]                         w_cnt_inc;
    logic signed [OUTPUT_WIDTH-1:0]        w_t;
    logic [VECTOR_WIDTH*DATA_WIDTH-1:0]    w_requant;

    assign w_accept  = (r_state == S_ACC) && bus.in_valid;
    assign w_cnt_inc = r_cnt + LW'(1);

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next-state logic; the len-th accepted beat ends ACC in the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = S_BIAS;
            S_BIAS:  w_next = (r_len == '0) ? S_DRAIN : S_ACC;
            S_ACC:   if (w_accept && (w_cnt_inc == r_len)) w_next = S_DRAIN;
            S_DRAIN: w_next = S_WB;
            S_WB:    w_next = S_OUT;
            S_OUT:   if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // outputs; operands are zero unless a beat is accepted so the FMA only adds zero while idle or stalled
    always_comb begin
        bus.busy       = (r_state != S_IDLE);
        bus.in_ready   = (r_state == S_ACC);
        bus.out_valid  = (r_state == S_OUT);
        bus.fma_mode   = r_run && (r_state != S_BIAS);
        bus.fma_val    = w_accept ? bus.in_val    : '0;
        bus.fma_weight = w_accept ? bus.in_weight : '0;
        bus.fma_bias   = r_bias;
        bus.out_data   = r_out_data;
    end

    // r_run keeps fma_mode low while in reset and lets it rise on the first clock afterwards
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

    // job registers are loaded only when a job is accepted in IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_len   <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
            r_bias  <= '0;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_len   <= bus.len;
            r_shift <= bus.shift;
            r_relu  <= bus.relu_en;
            r_bias  <= bus.bias;
        end
    end

    // beat counter: cleared per job, advanced on each accepted beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                 r_cnt <= '0;
        else if ((r_state == S_IDLE) && bus.start) r_cnt <= '0;
        else if (w_accept)                         r_cnt <= w_cnt_inc;
    end

    // per-lane requant: arithmetic shift, optional ReLU, saturate to the activation range
    always_comb begin
        w_requant = '0;
        w_t       = '0;
        for (int i = 0; i < VECTOR_WIDTH; i++) begin
            w_t = $signed(bus.fma_sum[i*OUTPUT_WIDTH +: OUTPUT_WIDTH]) >>> r_shift;
            if (r_relu && (w_t < 0)) w_t = '0;
            if (w_t > SAT_MAX)       w_t = SAT_MAX;
            else if (w_t < SAT_MIN)  w_t = SAT_MIN;
            w_requant[i*DATA_WIDTH +: DATA_WIDTH] = w_t[DATA_WIDTH-1:0];
        end
    end

    // result register: captured once in WB and held through OUT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                r_out_data <= '0;
        else if (r_state == S_WB) r_out_data <= w_requant;
    end
endmodule

// File: tb/tb_fma_layer_seq.sv
// tb/tb_fma_layer_seq.sv - self-checking bench for fma_layer_seq with FMA responder model
module tb_fma_layer_seq;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int VW = 4;
    localparam int OW = 16;
    localparam int ML = 256;
    localparam int LW = $clog2(ML + 1);
    localparam int SW = $clog2(OW);

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    int bv [0:ML-1][0:VW-1];
    int bw [0:ML-1][0:VW-1];

    fma_layer_seq_if #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .VECTOR_WIDTH(VW),
                       .OUTPUT_WIDTH(OW), .MAX_LEN(ML)) bus ();

    fma_layer_seq #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .VECTOR_WIDTH(VW),
                    .OUTPUT_WIDTH(OW), .MAX_LEN(ML)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FMA responder
    function automatic logic signed [OW-1:0] mul(input logic signed [DW-1:0] a,
                                                 input logic signed [WW-1:0] b);
        logic signed [OW-1:0] ea;
        logic signed [OW-1:0] eb;
        ea = a;
        eb = b;
        return ea * eb;
    endfunction

    logic signed [OW-1:0] f_prod [VW];
    logic signed [OW-1:0] f_sum  [VW];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < VW; i++) begin
                f_prod[i] <= '0;
                f_sum[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < VW; i++) begin
                f_prod[i] <= mul(bus.fma_val[i*DW +: DW], bus.fma_weight[i*WW +: WW]);
                f_sum[i]  <= bus.fma_mode ? f_sum[i] + f_prod[i]
                                          : $signed(bus.fma_bias[i*OW +: OW]);
            end
        end
    end

    always_comb begin
        bus.fma_sum = '0;
        for (int i = 0; i < VW; i++) bus.fma_sum[i*OW +: OW] = f_sum[i];
    end

    function automatic logic [VW*OW-1:0] pk_ow(input int a0, input int a1, input int a2, input int a3);
        logic [VW*OW-1:0] r;
        r = {OW'(a3), OW'(a2), OW'(a1), OW'(a0)};
        return r;
    endfunction

    function automatic logic [VW*DW-1:0] pk_dw(input int a0, input int a1, input int a2, input int a3);
        logic [VW*DW-1:0] r;
        r = {DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
        return r;
    endfunction

    // reference: bias plus dot product, wrapped to the accumulator width, then requant
    function automatic logic [VW*DW-1:0] ref_result(input logic [VW*OW-1:0] b, input int n,
                                                    input int sh, input bit relu);
        logic [VW*DW-1:0]     r;
        logic signed [OW-1:0] w;
        int acc;
        int t;
        r = '0;
        for (int i = 0; i < VW; i++) begin
            acc = $signed(b[i*OW +: OW]);
            for (int k = 0; k < n; k++) acc += bv[k][i] * bw[k][i];
            w = acc[OW-1:0];
            t = int'(w) >>> sh;
            if (relu && t < 0) t = 0;
            if (t > 127)  t = 127;
            if (t < -128) t = -128;
            r[i*DW +: DW] = t[DW-1:0];
        end
        return r;
    endfunction

    function automatic void fill_beats(input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < VW; i++) begin
                bv[k][i] = int'($urandom_range(0, 255)) - 128;
                bw[k][i] = int'($urandom_range(0, 255)) - 128;
            end
    endfunction

    // drives one job; mode 0 = always valid, 1 = pattern 1,0,0,1,0,1, 2 = random stalls
    task automatic run_job(input int n, input int sh, input bit relu, input logic [VW*OW-1:0] b,
                           input int mode, output logic [VW*DW-1:0] res, output int lat,
                           output int acc_cnt, output bit rdy_after, output bit tmo);
        bit pat [6];
        int e;
        int p;
        bit last_seen;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        e = 0; p = 0; acc_cnt = 0; rdy_after = 1'b1; last_seen = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len     = LW'(n);
        bus.shift   = SW'(sh);
        bus.relu_en = relu;
        bus.bias    = b;
        @(negedge clk);
        bus.start = 1'b0;
        while (!bus.out_valid && e < 3000) begin
            if (last_seen) begin
                rdy_after = bus.in_ready;
                last_seen = 1'b0;
            end
            case (mode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = pat[p % 6];
                default: bus.in_valid = 1'($urandom_range(0, 1));
            endcase
            for (int i = 0; i < VW; i++) begin
                bus.in_val[i*DW +: DW]    = (acc_cnt < n) ? DW'(bv[acc_cnt][i]) : DW'($urandom);
                bus.in_weight[i*WW +: WW] = (acc_cnt < n) ? WW'(bw[acc_cnt][i]) : WW'($urandom);
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cnt++;
                if (acc_cnt == n) last_seen = 1'b1;
            end
            if (bus.in_ready) p++;
            @(negedge clk);
            e++;
        end
        tmo = !bus.out_valid;
        lat = e;
        res = bus.out_data;
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.shift = '0; bus.relu_en = 1'b0; bus.bias = '0;
        bus.in_valid = 1'b0; bus.in_val = '0; bus.in_weight = '0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.in_ready, bus.out_valid, bus.fma_mode, bus.out_data,
             bus.fma_val, bus.fma_weight, bus.fma_bias} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs busy=%b rdy=%b ov=%b mode=%b od=%h", bus.busy,
                     bus.in_ready, bus.out_valid, bus.fma_mode, bus.out_data);
        end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.fma_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_after_reset busy=%b mode=%b exp busy=0 mode=1", bus.busy, bus.fma_mode);
        end
    endtask

    task automatic test_basic();
        logic [VW*DW-1:0] res;
        int lat, acc; bit rdy, tmo;
        for (int k = 0; k < 3; k++) for (int i = 0; i < VW; i++) begin bv[k][i] = 2; bw[k][i] = 3; end
        run_job(3, 0, 1'b0, pk_ow(10, 10, 10, 10), 0, res, lat, acc, rdy, tmo);
        n_checks++;
        if (tmo || res !== pk_dw(28, 28, 28, 28)) begin
            n_fail++; $display("FAIL basic_result got %h exp %h tmo=%b", res, pk_dw(28, 28, 28, 28), tmo);
        end
        n_checks++;
        if (lat !== 6) begin n_fail++; $display("FAIL basic_latency got %0d exp 6", lat); end
        n_checks++;
        if (acc !== 3) begin n_fail++; $display("FAIL basic_beats got %0d exp 3", acc); end
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_one_cycle_valid ov=%b busy=%b exp 0 0", bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_stall();
        logic [VW*DW-1:0] res;
        int lat, acc; bit rdy, tmo;
        for (int k = 0; k < 3; k++) for (int i = 0; i < VW; i++) begin bv[k][i] = 2; bw[k][i] = 3; end
        run_job(3, 0, 1'b0, pk_ow(10, 10, 10, 10), 1, res, lat, acc, rdy, tmo);
        n_checks++;
        if (tmo || res !== pk_dw(28, 28, 28, 28)) begin
            n_fail++; $display("FAIL stall_result got %h exp %h tmo=%b", res, pk_dw(28, 28, 28, 28), tmo);
        end
        n_checks++;
        if (acc !== 3) begin n_fail++; $display("FAIL stall_beats got %0d exp 3", acc); end
        n_checks++;
        if (rdy !== 1'b0) begin n_fail++; $display("FAIL stall_ready_drop got %b exp 0", rdy); end
        n_checks++;
        if (lat !== 9) begin n_fail++; $display("FAIL stall_latency got %0d exp 9", lat); end
    endtask

    task automatic test_len0();
        logic [VW*DW-1:0] res;
        int lat, acc; bit rdy, tmo;
        run_job(0, 0, 1'b0, pk_ow(1000, -1000, -50, 5), 0, res, lat, acc, rdy, tmo);
        n_checks++;
        if (tmo || res !== pk_dw(127, -128, -50, 5)) begin
            n_fail++; $display("FAIL len0_sat got %h exp %h", res, pk_dw(127, -128, -50, 5));
        end
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL len0_latency got %0d exp 3", lat); end
        run_job(0, 0, 1'b1, pk_ow(1000, -1000, -50, 5), 0, res, lat, acc, rdy, tmo);
        n_checks++;
        if (tmo || res !== pk_dw(127, 0, 0, 5)) begin
            n_fail++; $display("FAIL len0_relu got %h exp %h", res, pk_dw(127, 0, 0, 5));
        end
    endtask

    task automatic test_shift();
        logic [VW*DW-1:0] res;
        int lat, acc; bit rdy, tmo;
        for (int i = 0; i < VW; i++) begin bv[0][i] = (i % 2 == 0) ? 7 : -7; bw[0][i] = 4; end
        run_job(1, 2, 1'b0, '0, 0, res, lat, acc, rdy, tmo);
        n_checks++;
        if (tmo || res !== pk_dw(7, -7, 7, -7)) begin
            n_fail++; $display("FAIL shift2 got %h exp %h", res, pk_dw(7, -7, 7, -7));
        end
        run_job(1, 3, 1'b0, '0, 0, res, lat, acc, rdy, tmo);
        n_checks++;
        if (tmo || res !== pk_dw(3, -4, 3, -4)) begin
            n_fail++; $display("FAIL shift3 got %h exp %h", res, pk_dw(3, -4, 3, -4));
        end
    endtask

    task automatic test_backpressure();
        logic [VW*DW-1:0] held;
        logic [VW*OW-1:0] b1;
        int e;
        b1 = pk_ow(300, -7, 64, -129);
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.len = '0; bus.shift = '0; bus.relu_en = 1'b0; bus.bias = b1;
        @(negedge clk);
        bus.start = 1'b0;
        e = 0;
        while (!bus.out_valid && e < 50) begin @(negedge clk); e++; end
        held = bus.out_data;
        n_checks++;
        if (!bus.out_valid || held !== pk_dw(127, -7, 64, -128)) begin
            n_fail++; $display("FAIL bp_result got %h exp %h ov=%b", held, pk_dw(127, -7, 64, -128), bus.out_valid);
        end
        for (int c = 0; c < 5; c++) begin
            bus.start = 1'b1;
            bus.bias  = pk_ow(1, 2, 3, 4);
            @(negedge clk);
            n_checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== held || bus.busy !== 1'b1 || bus.fma_bias !== b1) begin
                n_fail++;
                $display("FAIL bp_hold cyc %0d ov=%b od=%h busy=%b fb=%h exp 1 %h 1 %h", c,
                         bus.out_valid, bus.out_data, bus.busy, bus.fma_bias, held, b1);
            end
        end
        bus.start = 1'b0;
        bus.bias  = b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL bp_release ov=%b busy=%b exp 0 0", bus.out_valid, bus.busy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_restart busy=%b exp 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        logic [VW*DW-1:0] res;
        int lat, acc, k, e; bit rdy, tmo;
        fill_beats(4);
        @(negedge clk);
        bus.start = 1'b1; bus.len = LW'(4); bus.shift = '0; bus.relu_en = 1'b0;
        bus.bias = pk_ow(55, -55, 77, 99);
        @(negedge clk);
        bus.start = 1'b0;
        k = 0; e = 0;
        while (k < 2 && e < 50) begin
            bus.in_valid = 1'b1;
            for (int i = 0; i < VW; i++) begin
                bus.in_val[i*DW +: DW]    = DW'(bv[k][i]);
                bus.in_weight[i*WW +: WW] = WW'(bw[k][i]);
            end
            if (bus.in_ready) k++;
            @(negedge clk);
            e++;
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if ({bus.busy, bus.in_ready, bus.out_valid, bus.fma_mode, bus.out_data,
             bus.fma_val, bus.fma_weight, bus.fma_bias} !== '0 || k != 2) begin
            n_fail++;
            $display("FAIL midreset_outputs busy=%b rdy=%b mode=%b fv=%h fb=%h beats=%0d exp all 0",
                     bus.busy, bus.in_ready, bus.fma_mode, bus.fma_val, bus.fma_bias, k);
        end
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < VW; i++) begin bv[0][i] = 1; bw[0][i] = 1; end
        run_job(1, 0, 1'b0, pk_ow(1, 1, 1, 1), 0, res, lat, acc, rdy, tmo);
        n_checks++;
        if (tmo || res !== pk_dw(2, 2, 2, 2)) begin
            n_fail++; $display("FAIL midreset_next_job got %h exp %h", res, pk_dw(2, 2, 2, 2));
        end
    endtask

    task automatic test_random();
        logic [VW*DW-1:0] res, exp;
        logic [VW*OW-1:0] b;
        int lat, acc, n, sh, mode; bit rdy, tmo, relu;
        for (int j = 0; j < 10; j++) begin
            n    = int'($urandom_range(0, 12));
            sh   = int'($urandom_range(0, 15));
            relu = 1'($urandom_range(0, 1));
            mode = (j % 3 == 0) ? 0 : 2;
            b    = {$urandom, $urandom};
            fill_beats(n);
            exp = ref_result(b, n, sh, relu);
            run_job(n, sh, relu, b, mode, res, lat, acc, rdy, tmo);
            n_checks++;
            if (tmo || res !== exp) begin
                n_fail++; $display("FAIL rand_result job %0d got %h exp %h tmo=%b", j, res, exp, tmo);
            end
            n_checks++;
            if (acc !== n) begin n_fail++; $display("FAIL rand_beats job %0d got %0d exp %0d", j, acc, n); end
            if (mode == 0) begin
                n_checks++;
                if (lat !== n + 3) begin
                    n_fail++; $display("FAIL rand_latency job %0d got %0d exp %0d", j, lat, n + 3);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_stall();
        test_len0();
        test_shift();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
